wave_sel_ctrl: RTL
==================

# wave_sel_ctrl

Sequential controller that produces the 3-bit waveform select consumed by the 5-input output mux of the DDS synthesizer. It turns two raw push-buttons (next/prev) and a direct load port into a target selection, holds it, and commits it to `sel` only on a phase-accumulator wrap pulse, so waveform switches never cause mid-cycle discontinuities. It sits between the top-level I/O pins and the mux select input.

## Interface
- `DB_MAX`, 50000: debounce length; a button level must differ from the debounced level for this many consecutive cycles to be accepted (≥2).
- `DB_W`, 16: width of the debounce counter; must satisfy 2^DB_W > DB_MAX.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `btn_next`  input  1  raw asynchronous button: advance selection.
- `btn_prev`  input  1  raw asynchronous button: retreat selection.
- `load_en`  input  1  synchronous strobe: load `load_sel` into target.
- `load_sel`  input  3  direct target value; legal range 0..4.
- `phase_wrap`  input  1  one-cycle pulse from the phase accumulator at wrap.
- `sel`  output  3  committed mux select, 0..4.
- `pending`  output  1  high while target ≠ `sel`.
- `sel_changed`  output  1  one-cycle pulse on the cycle after `sel` updates.

## Operation
- Each button: 2-flop synchronizer → debouncer → rising-edge detect on the debounced level; the edge is a one-cycle request.
- Debouncer: counter clears whenever the synchronized level equals the debounced level; otherwise increments. When the counter is DB_MAX-1 and the levels still differ, debounced level ← synchronized level and counter ← 0.
- Target register `tgt` (3 bits), updated per cycle with priority:
  - `load_en`=1 and `load_sel`≤4 → `tgt`←`load_sel`. `load_sel`≥5 → request ignored; next/prev are still evaluated this cycle.
  - next and prev requests in the same cycle → no change.
  - next only → `tgt`+1, with 4 wrapping to 0.
  - prev only → `tgt`-1, with 0 wrapping to 4.
- Commit: on a cycle with `phase_wrap`=1 and `tgt`≠`sel`, `sel`←`tgt` (the value before any same-cycle update). A target change made in that same cycle waits for the next wrap.
- `phase_wrap` with `tgt`=`sel` → no change, no pulse.
- `pending` is combinational from registers: (`tgt`≠`sel`).
- `sel` is never outside 0..4.

## Timing
- Reset (async assert, sync-safe deassert): `sel`=0, `tgt`=0, `pending`=0, `sel_changed`=0; synchronizers, debounced levels and counters are 0.
- Reset asserted mid-debounce or while pending: all state is discarded immediately. No commit occurs after release until a new request arrives.
- Button press to request pulse: 2 (sync) + DB_MAX cycles, plus 1 cycle for edge detect.
- Request to `tgt` update: 1 clock. `pending` is high from that cycle.
- Commit: `sel` updates on the `phase_wrap` edge. `sel_changed` is registered and is high for exactly the following cycle. `pending` drops in the same cycle `sel` updates.
- Button release produces no request. A bounce shorter than DB_MAX cycles produces nothing.

## Structure
- Shared package `dds_pkg`: `SEL_W`=3, `N_WAVES`=5, `SEL_MAX`=3'd4, and the waveform-index constants also used by the mux instantiation.
- One sub-module `btn_debounce` (synchronizer + debounce counter + rising-edge pulse, parameterized by `DB_MAX`/`DB_W`), instantiated twice.
- `wave_sel_ctrl` itself holds `tgt`, `sel`, `sel_changed` and the priority/wrap logic.

## Test plan
Benches use `DB_MAX`=4.
- **Reset:** reset, then hold `btn_next`=1 for 3 cycles, release, and pulse `phase_wrap` → `tgt` unchanged, `sel`=0, `pending`=0, `sel_changed` never high.
- **Next with wrap:** after reset, press next 5 times, each held for ≥8 cycles and released for ≥8 cycles, with a `phase_wrap` after each press → `sel` follows 1,2,3,4,0. Each commit gives a one-cycle `sel_changed`. Request-to-`tgt` latency is 7 cycles from the press edge.
- **Prev wrap and deferred commit:** from `sel`=0, press prev with no `phase_wrap` → `tgt`=4, `pending`=1, `sel`=0. Pulse `phase_wrap` → `sel`=4, `pending`=0.
- **Load priority and illegal value:**
  - `load_en` with `load_sel`=3 in the same cycle as a next request → `tgt`=3.
  - `load_sel`=6 with no button request → `tgt` unchanged.
  - `load_sel`=7 with a next request from `tgt`=2 → `tgt`=3.
- **Simultaneous events:** next and prev requests on the same cycle → `tgt` unchanged. With `tgt`=2 and `sel`=1, `load_en` `load_sel`=4 on a `phase_wrap` cycle → `sel`=2, `tgt`=4, `pending` still 1; the next wrap → `sel`=4.
- **Reset mid-operation:** with `tgt`=3, `sel`=1 pending, assert `rst_n`=0 between clock edges → `sel`=0 and `pending`=0 immediately. After release, a `phase_wrap` yields no change.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared DDS constants: waveform select width, waveform count and the mux
// index assignments, plus wrap-around step helpers for the select value.
package dds_pkg;

  localparam int          SEL_W   = 3;
  localparam int          N_WAVES = 5;
  localparam logic [2:0]  SEL_MAX = 3'd4;

  localparam logic [SEL_W-1:0] WAVE_SINE     = 3'd0;
  localparam logic [SEL_W-1:0] WAVE_TRIANGLE = 3'd1;
  localparam logic [SEL_W-1:0] WAVE_SAW      = 3'd2;
  localparam logic [SEL_W-1:0] WAVE_SQUARE   = 3'd3;
  localparam logic [SEL_W-1:0] WAVE_NOISE    = 3'd4;

  function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
    return (s >= SEL_MAX) ? '0 : s + 3'd1;
  endfunction

  function automatic logic [SEL_W-1:0] sel_dec(input logic [SEL_W-1:0] s);
    return (s == '0 || s > SEL_MAX) ? SEL_MAX : s - 3'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioning: two-flop synchronizer, consecutive-cycle
// debounce counter, and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int DB_MAX = 50000,
  parameter int DB_W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_MAX - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic            db_dly_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  // Decoded from registers only, so the request is clean for the consumer.
  assign pulse_o = db_q & ~db_dly_q;

endmodule

// File: rtl/wave_sel_ctrl.sv
// Waveform select controller: buttons and direct load steer a target value,
// which is committed to the mux select only on a phase-accumulator wrap.
module wave_sel_ctrl
  import dds_pkg::*;
#(
  parameter int DB_MAX = 50000,
  parameter int DB_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             load_en,
  input  logic [SEL_W-1:0] load_sel,
  input  logic             phase_wrap,
  output logic [SEL_W-1:0] sel,
  output logic             pending,
  output logic             sel_changed
);

  logic             req_next, req_prev;
  logic [SEL_W-1:0] tgt_q, tgt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             chg_q, chg_d;

  btn_debounce #(.DB_MAX(DB_MAX), .DB_W(DB_W)) u_db_next (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_next),
    .pulse_o (req_next)
  );

  btn_debounce #(.DB_MAX(DB_MAX), .DB_W(DB_W)) u_db_prev (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_prev),
    .pulse_o (req_prev)
  );

  // An out-of-range load is dropped, letting the buttons act this cycle.
  always_comb begin
    tgt_d = tgt_q;
    if (load_en && (load_sel <= SEL_MAX)) begin
      tgt_d = load_sel;
    end else if (req_next && !req_prev) begin
      tgt_d = sel_inc(tgt_q);
    end else if (req_prev && !req_next) begin
      tgt_d = sel_dec(tgt_q);
    end
  end

  // Commit uses the pre-update target; a same-cycle change waits for the next wrap.
  always_comb begin
    sel_d = sel_q;
    chg_d = 1'b0;
    if (phase_wrap && (tgt_q != sel_q)) begin
      sel_d = tgt_q;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_q <= '0;
      sel_q <= '0;
      chg_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      sel_q <= sel_d;
      chg_q <= chg_d;
    end
  end

  assign sel         = sel_q;
  assign pending     = (tgt_q != sel_q);
  assign sel_changed = chg_q;

endmodule
